sign_extension: RTL and testbench
=================================

SIGN_EXTENSION -- requirements
Module: sign_extension

Interface
REQ-001 Parameters: none; the data width is fixed at 32 bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 Q  output  32  registered, sign-extended result.
REQ-006 D  input  32  source data; the operand occupies the low bits selected by dataSize.
REQ-007 dataSize  input  2  operand size: 00 = byte, 01 = halfword, 10 = word, 11 = word.
REQ-008 E  input  1  load enable; active high.
REQ-009 Positional port order SHALL be Q, D, dataSize, E, CLK, RST_N.

Function
REQ-010 On a CLK rising edge with E=1, Q SHALL load ext(D, dataSize).
REQ-011 On a CLK rising edge with E=0, Q SHALL hold its previous value.
REQ-012 For dataSize=00, ext SHALL produce {24{D[7]}, D[7:0]}.
REQ-013 For dataSize=01, ext SHALL produce {16{D[15]}, D[15:0]}.
REQ-014 For dataSize=10 and dataSize=11, ext SHALL produce D unchanged.
REQ-015 Unused upper bits of D SHALL NOT affect Q.
REQ-016 Latency SHALL be exactly 1 clock edge from the sampled D/dataSize/E to Q.
REQ-017 D, dataSize and E SHALL be sampled only at the rising edge; changes between edges SHALL NOT alter Q.
REQ-018 ext SHALL be pure combinational logic with no X propagation for defined inputs; any unknown dataSize SHALL resolve to the word behaviour.

Reset
REQ-019 RST_N=0 SHALL force Q to 0x00000000 immediately, independent of CLK and E.
REQ-020 While RST_N=0, rising edges SHALL NOT load Q.
REQ-021 Loading SHALL resume on the first rising edge after RST_N returns to 1, with E=1.
REQ-022 If reset is asserted mid-operation, the held value SHALL be lost and Q SHALL read 0.

Structure
REQ-023 A shared package SHALL hold the dataSize encodings: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_WORD2=2'b11.
REQ-024 The package SHALL also hold the constant DATA_W=32.
REQ-025 One combinational sub-module, sign_ext_core (D, dataSize -> extended value), SHALL be instantiated.
REQ-026 A single 32-bit register SHALL be instantiated in sign_extension.

Verification
REQ-027 Reset: RST_N=0 with Q previously 0xF0E47492 -> Q=0x00000000 immediately, before any clock edge.
REQ-028 D=0x0000FF03, E=1: size 00 -> Q=0x00000003; size 01 -> Q=0xFFFFFF03; sizes 10 and 11 -> Q=0x0000FF03, each one edge later.
REQ-029 D=0xF0E47492, E=1: size 00 -> Q=0xFFFFFF92; size 01 -> Q=0x00007492; size 10 -> Q=0xF0E47492.
REQ-030 E=0 with D and dataSize toggling for 5 edges -> Q unchanged; E=1 -> Q updates on the next edge.
REQ-031 D changes between edges (e.g. 0x0000FF03 to 0xF0E47492 mid-cycle, size 01) -> Q changes only at the next rising edge, to 0x00007492.
REQ-032 Boundaries: D=0x00000080 size 00 -> 0xFFFFFF80; D=0x0000007F size 00 -> 0x0000007F; D=0x00008000 size 01 -> 0xFFFF8000.

Source files
------------

// File: rtl/sign_extension_pkg.sv
// sign_extension_pkg: shared operand-size encodings and datapath width.
package sign_extension_pkg;
  localparam int DATA_W = 32;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_WORD2 = 2'b11;
endpackage

// File: rtl/sign_ext_core.sv
// sign_ext_core: combinational sign extension of the low byte/halfword/word of d_i.
module sign_ext_core
  import sign_extension_pkg::*;
(
  input  logic [DATA_W-1:0] d_i,
  input  logic [1:0]        size_i,
  output logic [DATA_W-1:0] ext_o
);
  // default arm catches both word encodings and any unknown size
  always_comb begin
    ext_o = d_i;
    case (size_i)
      SZ_BYTE: ext_o = {{24{d_i[7]}}, d_i[7:0]};
      SZ_HALF: ext_o = {{16{d_i[15]}}, d_i[15:0]};
      default: ext_o = d_i;
    endcase
  end
endmodule

// File: rtl/sign_extension.sv
// sign_extension: registered sign extension with load enable and async active-low reset.
module sign_extension
  import sign_extension_pkg::*;
(
  output logic [DATA_W-1:0] Q,
  input  logic [DATA_W-1:0] D,
  input  logic [1:0]        dataSize,
  input  logic              E,
  input  logic              CLK,
  input  logic              RST_N
);
  logic [DATA_W-1:0] ext, q_d, q_q;
  sign_ext_core u_core (
    .d_i    (D),
    .size_i (dataSize),
    .ext_o  (ext)
  );
  assign q_d = E ? ext : q_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) q_q <= '0;
    else        q_q <= q_d;
  end
  assign Q = q_q;
endmodule

// File: tb/tb_sign_extension.sv
// tb_sign_extension: randomized and directed checks against an arithmetic reference model.
module tb_sign_extension;
  logic [31:0] Q, D;
  logic [1:0]  dataSize;
  logic        E, CLK, RST_N;
  int tests = 0, fails = 0;
  logic [31:0] qm;

  sign_extension dut (
    .Q(Q), .D(D), .dataSize(dataSize), .E(E), .CLK(CLK), .RST_N(RST_N)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] model(input logic [31:0] d, input logic [1:0] sz);
    int v;
    if (sz == 2'd0) v = int'($signed(d[7:0]));
    else if (sz == 2'd1) v = int'($signed(d[15:0]));
    else v = int'(d);
    return 32'(v);
  endfunction

  task automatic step(input logic [31:0] d, input logic [1:0] sz, input logic e);
    @(negedge CLK);
    D = d; dataSize = sz; E = e;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    step(32'hF0E47492, 2'd2, 1'b1);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    tests++;
    if (Q !== 32'h0) begin fails++; $display("FAIL reset_async: Q=%h want %h", Q, 32'h0); end
    D = 32'h12345678; dataSize = 2'd2; E = 1'b1;
    @(posedge CLK); #1;
    tests++;
    if (Q !== 32'h0) begin fails++; $display("FAIL reset_no_load: Q=%h want %h", Q, 32'h0); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    tests++;
    if (Q !== 32'h12345678) begin fails++; $display("FAIL reset_resume: Q=%h want %h", Q, 32'h12345678); end
  endtask

  task automatic test_vectors();
    logic [31:0] ds [7] = '{32'h0000FF03, 32'h0000FF03, 32'h0000FF03, 32'h0000FF03,
                            32'hF0E47492, 32'hF0E47492, 32'hF0E47492};
    logic [1:0]  ss [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [31:0] ex [7] = '{32'h00000003, 32'hFFFFFF03, 32'h0000FF03, 32'h0000FF03,
                            32'hFFFFFF92, 32'h00007492, 32'hF0E47492};
    for (int i = 0; i < 7; i++) begin
      step(ds[i], ss[i], 1'b1);
      tests++;
      if (Q !== ex[i]) begin fails++; $display("FAIL vector_%0d: Q=%h want %h", i, Q, ex[i]); end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] ds [4] = '{32'h00000080, 32'h0000007F, 32'h00008000, 32'hFFFF7FFF};
    logic [1:0]  ss [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic [31:0] ex [4] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF8000, 32'h00007FFF};
    for (int i = 0; i < 4; i++) begin
      step(ds[i], ss[i], 1'b1);
      tests++;
      if (Q !== ex[i]) begin fails++; $display("FAIL boundary_%0d: Q=%h want %h", i, Q, ex[i]); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] held, d;
    step(32'hA5A5C3C3, 2'd2, 1'b1);
    held = 32'hA5A5C3C3;
    for (int i = 0; i < 5; i++) begin
      step($urandom, 2'($urandom_range(0, 3)), 1'b0);
      tests++;
      if (Q !== held) begin fails++; $display("FAIL hold_%0d: Q=%h want %h", i, Q, held); end
    end
    d = $urandom;
    step(d, 2'd0, 1'b1);
    tests++;
    if (Q !== model(d, 2'd0)) begin fails++; $display("FAIL hold_release: Q=%h want %h", Q, model(d, 2'd0)); end
  endtask

  task automatic test_midcycle();
    step(32'h0, 2'd2, 1'b1);
    @(negedge CLK);
    D = 32'h0000FF03; dataSize = 2'd1; E = 1'b1;
    #2 D = 32'hF0E47492;
    #1;
    tests++;
    if (Q !== 32'h0) begin fails++; $display("FAIL midcycle_pre: Q=%h want %h", Q, 32'h0); end
    @(posedge CLK); #1;
    tests++;
    if (Q !== 32'h00007492) begin fails++; $display("FAIL midcycle_post: Q=%h want %h", Q, 32'h00007492); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [1:0]  sz;
    logic        e;
    qm = Q;
    for (int i = 0; i < 300; i++) begin
      d = $urandom; sz = 2'($urandom_range(0, 3)); e = 1'($urandom_range(0, 1));
      if (e) qm = model(d, sz);
      step(d, sz, e);
      tests++;
      if (Q !== qm) begin fails++; $display("FAIL random_%0d: Q=%h want %h (d=%h sz=%0d e=%0b)", i, Q, qm, d, sz, e); end
    end
  endtask

  initial begin
    RST_N = 1'b0; D = '0; dataSize = '0; E = 1'b0;
    #12;
    tests++;
    if (Q !== 32'h0) begin fails++; $display("FAIL power_on_reset: Q=%h want %h", Q, 32'h0); end
    @(negedge CLK);
    RST_N = 1'b1;
    test_vectors();
    test_boundaries();
    test_hold();
    test_midcycle();
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
